// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline control unit: FSM states,
// fetch PC mux encodings and the stack-word count function.
package pipe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PUSH_PC,
        PUSH_FLAGS,
        VECTOR
    } state_t;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_VEC = 2'd2;

    function automatic int nwords(input int pc_w, input int word_w);
        return (pc_w + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Combinational load-use comparator: flags a decode instruction that reads
// the destination of a load still sitting in execute.
module hazard_detect #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    output logic                  hazard
);

    logic match1;
    logic match2;

    assign match1 = id_use1 && (id_src1 == ex_dst);
    assign match2 = id_use2 && (id_src2 == ex_dst);
    assign hazard = ex_valid && ex_mem_read && id_valid && (match1 || match2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stall, taken-branch flush and the interrupt
// entry sequencer (drain, push return PC words, push flags, vector).
module pipe_ctrl #(
    parameter int STAGES     = 5,
    parameter int REG_ADDR_W = 3,
    parameter int PC_W       = 32,
    parameter int WORD_W     = 16,
    parameter int FLAG_W     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  branch_taken,
    input  logic [PC_W-1:0]       branch_target,
    input  logic                  irq,
    input  logic [PC_W-1:0]       irq_pc,
    input  logic [FLAG_W-1:0]     flags,
    input  logic                  push_ready,
    output logic                  stall,
    output logic                  flush_fd,
    output logic                  flush_de,
    output logic [1:0]            pc_sel,
    output logic                  push_valid,
    output logic [WORD_W-1:0]     push_data,
    output logic                  busy
);
    import pipe_pkg::*;

    localparam int NWORDS  = nwords(PC_W, WORD_W);
    localparam int EXT_W   = NWORDS * WORD_W;
    localparam int DRAIN_W = $clog2(STAGES);
    localparam int WORD_CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(STAGES - 3);
    localparam logic [WORD_CW-1:0] WORD_LOAD  = WORD_CW'(NWORDS - 1);

    state_t state;
    state_t next_state;

    logic                          hazard;
    logic                          pending;
    logic                          accept;
    logic                          push_fire;
    logic [DRAIN_W-1:0]            drain_cnt;
    logic [WORD_CW-1:0]            word_cnt;
    logic [PC_W-1:0]               ret_pc;
    logic [FLAG_W-1:0]             saved_flags;
    logic [EXT_W-1:0]              ret_ext;
    logic [NWORDS-1:0][WORD_W-1:0] ret_words;
    logic [WORD_W-1:0]             pc_word;
    logic [WORD_W-1:0]             flag_word;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_use1     (id_use1),
        .id_use2     (id_use2),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_dst      (ex_dst),
        .hazard      (hazard)
    );

    // A branch resolving in the same cycle pushes acceptance out by one cycle.
    assign accept    = (state == IDLE) && pending && !branch_taken;
    assign push_fire = push_valid && push_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (accept) next_state = DRAIN;
            DRAIN:      if (drain_cnt == DRAIN_LAST) next_state = PUSH_PC;
            PUSH_PC:    if (push_fire && (word_cnt == '0)) next_state = PUSH_FLAGS;
            PUSH_FLAGS: if (push_fire) next_state = VECTOR;
            VECTOR:     next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Word counter runs down so the most-significant word goes out first.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= 1'b0;
            drain_cnt   <= '0;
            word_cnt    <= '0;
            ret_pc      <= '0;
            saved_flags <= '0;
        end else begin
            pending <= irq || (pending && !accept);
            if (accept) begin
                drain_cnt   <= '0;
                ret_pc      <= irq_pc;
                saved_flags <= flags;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
                if (branch_taken) ret_pc <= branch_target;
            end
            if ((state == DRAIN) && (next_state == PUSH_PC)) begin
                word_cnt <= WORD_LOAD;
            end else if ((state == PUSH_PC) && push_fire) begin
                word_cnt <= word_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        ret_ext             = '0;
        ret_ext[PC_W-1:0]   = ret_pc;
        ret_words           = ret_ext;
        flag_word           = '0;
        flag_word[FLAG_W-1:0] = saved_flags;
        pc_word             = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (word_cnt == WORD_CW'(i)) pc_word = ret_words[i];
        end
    end

    always_comb begin
        stall      = 1'b0;
        flush_fd   = 1'b0;
        flush_de   = 1'b0;
        pc_sel     = PC_SEQ;
        push_valid = 1'b0;
        push_data  = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (branch_taken) begin
                    pc_sel   = PC_BR;
                    flush_fd = 1'b1;
                    flush_de = 1'b1;
                end else if (hazard) begin
                    stall    = 1'b1;
                    flush_de = 1'b1;
                end
            end
            DRAIN: begin
                stall    = 1'b1;
                flush_fd = 1'b1;
                busy     = 1'b1;
            end
            PUSH_PC: begin
                stall      = 1'b1;
                flush_fd   = 1'b1;
                busy       = 1'b1;
                push_valid = 1'b1;
                push_data  = pc_word;
            end
            PUSH_FLAGS: begin
                stall      = 1'b1;
                flush_fd   = 1'b1;
                busy       = 1'b1;
                push_valid = 1'b1;
                push_data  = flag_word;
            end
            VECTOR: begin
                flush_fd = 1'b1;
                pc_sel   = PC_VEC;
                busy     = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the N-stage processor core. It replaces the fixed 5-stage hazard logic and the interrupt call sequencer with one block. It issues stall and flush signals for load-use hazards and taken branches, and runs a multi-word interrupt entry sequence: drain, push the return PC in WORD_W-sized pieces, push flags, then select the vector. It sits beside fetch and decode and drives the FD/DE buffer controls, the fetch PC mux and the memory-stage stack-push port.

## Interface
- STAGES, 5, pipeline depth (≥4); drain length is STAGES−2 cycles
- REG_ADDR_W, 3, register address width
- PC_W, 32, program counter width
- WORD_W, 16, stack word width; NWORDS = ceil(PC_W/WORD_W)
- FLAG_W, 3, flag register width (≤ WORD_W)

Ports:
- clk  in  1  rising-edge clock (single clock; already decided)
- reset  in  1  synchronous, active-high (already decided)
- id_valid  in  1  decode stage holds a valid instruction
- id_src1, id_src2  in  REG_ADDR_W  decode source registers
- id_use1, id_use2  in  1  matching source actually read
- ex_valid, ex_mem_read  in  1  execute-stage instruction valid / is a load
- ex_dst  in  REG_ADDR_W  execute-stage destination register
- branch_taken  in  1  execute resolved a taken branch
- branch_target  in  PC_W  target of that branch
- irq  in  1  interrupt request, pulse or level
- irq_pc  in  PC_W  PC of the oldest not-yet-issued instruction
- flags  in  FLAG_W  current flag register
- push_ready  in  1  memory stage accepts a stack word
- stall  out  1  hold PC and FD buffer
- flush_fd, flush_de  out  1  bubble the FD / DE buffer
- pc_sel  out  2  0 sequential, 1 branch, 2 interrupt vector
- push_valid  out  1  stack word offered
- push_data  out  WORD_W  stack word
- busy  out  1  interrupt sequence active

## Operation
- **Load-use detection (combinational):** hazard = ex_valid & ex_mem_read & id_valid & ((id_use1 & id_src1==ex_dst) | (id_use2 & id_src2==ex_dst)).
  - On hazard: stall=1, flush_de=1 (one bubble).
- **Taken branch while IDLE:** pc_sel=1, flush_fd=1, flush_de=1, stall=0. A branch overrides the load-use hazard in the same cycle.
- **Pending bit:** set by irq=1 in any state. It is cleared only when the request is accepted. Further irq while busy or pending is merged into the same bit, never queued twice.
- **Acceptance:** in IDLE with pending=1 and branch_taken=0. A branch in the same cycle defers acceptance one cycle. On acceptance, ret_pc ← irq_pc and flags are captured into a register.
- **FSM states:**
  - IDLE: normal hazard handling.
  - DRAIN: STAGES−2 cycles. stall=1, flush_fd=1. If branch_taken occurs here, ret_pc ← branch_target and no pc_sel=1 is issued.
  - PUSH_PC: NWORDS words, most-significant word first. ret_pc is zero-extended to NWORDS·WORD_W. Advance on push_valid & push_ready.
  - PUSH_FLAGS: one word, captured flags zero-extended. Advance on handshake.
  - VECTOR: one cycle, pc_sel=2, flush_fd=1. Then IDLE.
- **Stall during the sequence:** stall=1 and flush_fd=1 in every non-IDLE state except VECTOR, where stall=0.
- **busy:** 1 in every non-IDLE state.
- **Push handshake:** push_valid stays high with push_data stable until push_ready. push_valid does not depend combinationally on push_ready.

## Timing
- Reset: the FSM goes to IDLE; pending, the counters, ret_pc and captured flags clear to 0. All outputs are 0 in the cycle after reset is sampled.
- A reset mid-sequence abandons the sequence. No partial-push recovery is done.
- Hazard and branch outputs are combinational from inputs, valid in the same cycle.
- FSM-driven outputs (push_*, busy, VECTOR pc_sel) are decoded from registered state. They do not depend combinationally on irq.
- Minimum entry latency with push_ready always 1 is (STAGES−2) + NWORDS + 1 + 1 cycles. For the defaults that is 3+2+1+1 = 7 cycles, from the acceptance edge to the VECTOR cycle.
- An irq arriving in VECTOR sets pending. It is accepted at the earliest in the first IDLE cycle that follows.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum {IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, VECTOR};
  - the pc_sel encodings (PC_SEQ=0, PC_BR=1, PC_VEC=2);
  - the NWORDS function.
- One natural sub-module, `hazard_detect`: the combinational load-use comparator, reusable by a forwarding-aware successor.
- Drain and word counters, pending, ret_pc and the flag capture live in the top level.

## Test plan
- **Load-use:** ex_mem_read=1, ex_dst=3, id_src1=3, id_use1=1 → stall=1, flush_de=1 for exactly one cycle. With id_use1=0 → no stall.
- **Branch over load-use:** the load-use hazard and branch_taken=1 in the same cycle → pc_sel=1, flush_fd=flush_de=1, stall=0.
- **Defaults, interrupt entry:** irq pulse with irq_pc=0x0001_2345, flags=3'b101, push_ready=1 → 3 drain cycles, then push_data 0x0001, 0x2345, 0x0005, then pc_sel=2 at cycle 7, then busy=0.
- **Backpressure:** push_ready=0 for 4 cycles during the first PC word → push_valid=1 and push_data=0x0001 held, no state advance.
- **Branch in DRAIN:** branch_taken with branch_target=0x0000_0040 in the 2nd drain cycle → the pushed words are 0x0000, 0x0040, and pc_sel never goes to 1.
- **Reset and re-request:** reset during PUSH_PC → IDLE next cycle, all outputs 0. A second irq while busy (before the reset) produces only a single sequence. Repeat the entry test with PC_W=16, WORD_W=16, STAGES=4 → 2 drain cycles, 1 PC word.
